exec_unit: RTL and testbench

Parametrised, clocked execution unit for the CPU. It owns the architectural state: registers A and B, the output port register, the PC and the carry flag. It accepts one decoded instruction per valid/ready handshake and updates that state. It generalises the 4-bit combinational datapath to any data width. It adds an instruction handshake and an optional multi-cycle multiply.

---
 rtl/exec_unit_pkg.sv | 34 +++
 rtl/exec_unit_mul.sv | 51 +++++
 rtl/exec_unit.sv | 118 +++++++++++
 tb/tb_exec_unit.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/exec_unit_pkg.sv
// Shared CPU packages: architectural register layout, exec FSM states and opcode map.
package lib_cpu;
  localparam int REG_W = 4;
  localparam int PC_W  = 4;

  typedef struct packed {
    logic [REG_W-1:0] a;
    logic [REG_W-1:0] b;
    logic [REG_W-1:0] outp;
    logic [PC_W-1:0]  pc;
    logic             carry;
  } REGS;

  typedef enum logic {IDLE, MUL} EXEC_STATE;
endpackage

package lib_operation;
  typedef enum logic [3:0] {
    ADD_A_IMM = 4'b0000,
    MOV_A_B   = 4'b0001,
    IN_A      = 4'b0010,
    MOV_A_IMM = 4'b0011,
    MOV_B_A   = 4'b0100,
    ADD_B_IMM = 4'b0101,
    IN_B      = 4'b0110,
    MOV_B_IMM = 4'b0111,
    MUL_A_B   = 4'b1000,
    OUT_B     = 4'b1001,
    NOP       = 4'b1010,
    OUT_IMM   = 4'b1011,
    JNC_IMM   = 4'b1110,
    JMP_IMM   = 4'b1111
  } OPECODE;
endpackage

// File: rtl/exec_unit_mul.sv
// WIDTH-cycle unsigned shift-add multiplier; present only when EXEC_UNIT_MUL_EN is defined.
`ifdef EXEC_UNIT_MUL_EN
module exec_mul #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic               r_busy;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] w_sum;

  // Final step's partial sum is exposed combinationally so the result lands on the last edge.
  assign w_sum   = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign done    = r_busy && (r_cnt == LAST);
  assign product = w_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (start) begin
      r_busy   <= 1'b1;
      r_cnt    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, a};
      r_mplier <= b;
      r_acc    <= '0;
    end else if (r_busy) begin
      r_acc    <= w_sum;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
      if (r_cnt == LAST) r_busy <= 1'b0;
    end
  end
endmodule
`endif

// File: rtl/exec_unit.sv
// CPU execution unit: owns A, B, OUT, PC, carry; one instruction per valid/ready accept.
// EXEC_UNIT_MUL_EN enables the multi-cycle MUL A,B (opcode 1000); otherwise that opcode is a NOP.
module exec_unit
  import lib_cpu::*;
  import lib_operation::*;
#(
  parameter int WIDTH    = 4,
  parameter int PC_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          opecode,
  input  logic [WIDTH-1:0]    imm,
  input  logic [WIDTH-1:0]    switch,
  output logic [PC_WIDTH-1:0] pc,
  output logic [WIDTH-1:0]    out_port,
  output logic                carry,
  output logic                busy
);
  typedef struct packed {
    logic [WIDTH-1:0]    a;
    logic [WIDTH-1:0]    b;
    logic [WIDTH-1:0]    outp;
    logic [PC_WIDTH-1:0] pc;
    logic                carry;
  } regs_t;

  regs_t               r_regs;
  logic                w_acc;
  logic [PC_WIDTH-1:0] w_pc_inc;
  logic [PC_WIDTH-1:0] w_imm_pc;
  logic [WIDTH:0]      w_add_a;
  logic [WIDTH:0]      w_add_b;

  assign w_acc    = in_valid && in_ready;
  assign w_pc_inc = r_regs.pc + PC_WIDTH'(1);
  assign w_add_a  = {1'b0, r_regs.a} + {1'b0, imm};
  assign w_add_b  = {1'b0, r_regs.b} + {1'b0, imm};

  generate
    if (WIDTH >= PC_WIDTH) begin : g_imm_trunc
      assign w_imm_pc = imm[PC_WIDTH-1:0];
    end else begin : g_imm_zext
      assign w_imm_pc = {{(PC_WIDTH-WIDTH){1'b0}}, imm};
    end
  endgenerate

  assign pc       = r_regs.pc;
  assign out_port = r_regs.outp;
  assign carry    = r_regs.carry;
  assign busy     = ~in_ready;

`ifdef EXEC_UNIT_MUL_EN
  EXEC_STATE          r_state;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_prod;

  exec_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (w_acc && (opecode == MUL_A_B)),
    .a       (r_regs.a),
    .b       (r_regs.b),
    .done    (w_mul_done),
    .product (w_prod)
  );

  assign in_ready = (r_state == IDLE);
`else
  assign in_ready = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regs  <= '0;
`ifdef EXEC_UNIT_MUL_EN
      r_state <= IDLE;
`endif
    end else begin
`ifdef EXEC_UNIT_MUL_EN
      if (r_state == MUL && w_mul_done) begin
        r_regs.a     <= w_prod[WIDTH-1:0];
        r_regs.b     <= w_prod[2*WIDTH-1:WIDTH];
        r_regs.carry <= |w_prod[2*WIDTH-1:WIDTH];
        r_state      <= IDLE;
      end
`endif
      if (w_acc) begin
        r_regs.pc    <= w_pc_inc;
        r_regs.carry <= 1'b0;
        case (opecode)
          ADD_A_IMM: {r_regs.carry, r_regs.a} <= w_add_a;
          MOV_A_B:   r_regs.a <= r_regs.b;
          IN_A:      r_regs.a <= switch;
          MOV_A_IMM: r_regs.a <= imm;
          MOV_B_A:   r_regs.b <= r_regs.a;
          ADD_B_IMM: {r_regs.carry, r_regs.b} <= w_add_b;
          IN_B:      r_regs.b <= switch;
          MOV_B_IMM: r_regs.b <= imm;
          OUT_B:     r_regs.outp <= r_regs.b;
          OUT_IMM:   r_regs.outp <= imm;
          // Carry tested before this instruction's own clear.
          JNC_IMM:   if (!r_regs.carry) r_regs.pc <= w_imm_pc;
          JMP_IMM:   r_regs.pc <= w_imm_pc;
`ifdef EXEC_UNIT_MUL_EN
          MUL_A_B: begin
            r_regs.carry <= r_regs.carry;
            r_state      <= MUL;
          end
`endif
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_exec_unit.sv
// Scoreboard bench for exec_unit: stimulus pushes expected post-accept state, monitor checks each accept.
module tb_exec_unit;
  localparam int W = 4;
  localparam int P = 4;
`ifdef EXEC_UNIT_MUL_EN
  localparam bit MULEN = 1'b1;
`else
  localparam bit MULEN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [3:0]   opecode = 4'h0;
  logic [W-1:0] imm = '0;
  logic [W-1:0] sw = '0;
  logic         in_ready, carry, busy;
  logic [P-1:0] pc;
  logic [W-1:0] out_port;

  exec_unit #(.WIDTH(W), .PC_WIDTH(P)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opecode(opecode), .imm(imm), .switch(sw), .pc(pc), .out_port(out_port),
    .carry(carry), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [P-1:0] pc;
    logic [W-1:0] outp;
    logic         c;
    logic         rdy;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   n_acc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] im, input logic [P-1:0] epc,
                       input logic [W-1:0] eout, input logic ec, input logic erdy);
    exp_t e;
    int   n;
    e.pc = epc; e.outp = eout; e.c = ec; e.rdy = erdy;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b1; opecode = op; imm = im;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; failures++;
      $display("FAIL accept_timeout op=%0h actual=not_accepted required=accepted", op);
    end else begin
      @(posedge clk);
    end
  endtask

  // Monitor: every accept edge must leave the state the scoreboard predicts.
  always @(posedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      exp_t e;
      #1;
      n_acc++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL accept%0d actual=unexpected_accept required=no_accept", n_acc);
      end else begin
        e = sb.pop_front();
        if (pc !== e.pc || out_port !== e.outp || carry !== e.c || in_ready !== e.rdy) begin
          failures++;
          $display("FAIL accept%0d actual pc=%0h out=%0h c=%0b rdy=%0b required pc=%0h out=%0h c=%0b rdy=%0b",
                   n_acc, pc, out_port, carry, in_ready, e.pc, e.outp, e.c, e.rdy);
        end
      end
    end
  end

  initial begin
    int lowcnt;
    #12;
    chk("rst_pc", 32'(pc), 0);
    chk("rst_out", 32'(out_port), 0);
    chk("rst_carry", 32'(carry), 0);
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;

    //     op    imm   pc    out   c     rdy
    issue(4'h3, 4'h5, 4'h1, 4'h0, 1'b0, 1'b1); // MOV A,5
    issue(4'h4, 4'h0, 4'h2, 4'h0, 1'b0, 1'b1); // MOV B,A
    issue(4'h9, 4'h0, 4'h3, 4'h5, 1'b0, 1'b1); // OUT B
    issue(4'h3, 4'hE, 4'h4, 4'h5, 1'b0, 1'b1); // MOV A,E
    issue(4'h0, 4'h3, 4'h5, 4'h5, 1'b1, 1'b1); // ADD A,3 -> 1, carry
    issue(4'hE, 4'hA, 4'h6, 4'h5, 1'b0, 1'b1); // JNC not taken
    issue(4'hE, 4'hA, 4'hA, 4'h5, 1'b0, 1'b1); // JNC taken
    issue(4'h4, 4'h0, 4'hB, 4'h5, 1'b0, 1'b1); // MOV B,A
    issue(4'h9, 4'h0, 4'hC, 4'h1, 1'b0, 1'b1); // OUT B shows A=1
    issue(4'hF, 4'hF, 4'hF, 4'h1, 1'b0, 1'b1); // JMP F
    issue(4'h3, 4'h0, 4'h0, 4'h1, 1'b0, 1'b1); // MOV A,0; pc wraps
    issue(4'hF, 4'h7, 4'h7, 4'h1, 1'b0, 1'b1); // JMP 7
    sw = 4'h9;
    issue(4'h6, 4'h0, 4'h8, 4'h1, 1'b0, 1'b1); // IN B
    issue(4'h9, 4'h0, 4'h9, 4'h9, 1'b0, 1'b1); // OUT B back-to-back
    issue(4'h5, 4'h7, 4'hA, 4'h9, 1'b1, 1'b1); // ADD B,7 -> 0, carry
    issue(4'hB, 4'h3, 4'hB, 4'h3, 1'b0, 1'b1); // OUT 3
    sw = 4'h6;
    issue(4'h2, 4'h0, 4'hC, 4'h3, 1'b0, 1'b1); // IN A
    issue(4'h0, 4'hF, 4'hD, 4'h3, 1'b1, 1'b1); // ADD A,F -> 5, carry
    issue(4'hA, 4'h0, 4'hE, 4'h3, 1'b0, 1'b1); // NOP clears carry
    issue(4'h7, 4'h2, 4'hF, 4'h3, 1'b0, 1'b1); // MOV B,2
    issue(4'h1, 4'h0, 4'h0, 4'h3, 1'b0, 1'b1); // MOV A,B
    issue(4'h3, 4'hD, 4'h1, 4'h3, 1'b0, 1'b1); // MOV A,D
    issue(4'h7, 4'hB, 4'h2, 4'h3, 1'b0, 1'b1); // MOV B,B
    issue(4'h8, 4'h0, 4'h3, 4'h3, 1'b0, !MULEN); // MUL (or NOP)

    lowcnt = 0;
    fork
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
          lowcnt++; n++;
          @(negedge clk);
        end
        chk("mul_ready_low_cycles", 32'(lowcnt), MULEN ? 4 : 0);
        chk("mul_carry", 32'(carry), MULEN ? 1 : 0);
      end
      issue(4'h9, 4'h0, 4'h4, MULEN ? 4'h8 : 4'hB, 1'b0, 1'b1); // held off during MUL
    join
    issue(4'h4, 4'h0, 4'h5, MULEN ? 4'h8 : 4'hB, 1'b0, 1'b1);
    issue(4'h9, 4'h0, 4'h6, MULEN ? 4'hF : 4'hD, 1'b0, 1'b1);

    // Reset two cycles into a MUL.
    issue(4'h8, 4'h0, 4'h7, MULEN ? 4'hF : 4'hD, 1'b0, !MULEN);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_pc", 32'(pc), 0);
    chk("midrst_out", 32'(out_port), 0);
    chk("midrst_carry", 32'(carry), 0);
    chk("midrst_ready", 32'(in_ready), 1);
    chk("midrst_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("postrst_pc", 32'(pc), 0);
    issue(4'h9, 4'h0, 4'h1, 4'h0, 1'b0, 1'b1); // B still 0
    issue(4'h4, 4'h0, 4'h2, 4'h0, 1'b0, 1'b1);
    issue(4'h9, 4'h0, 4'h3, 4'h0, 1'b0, 1'b1); // A still 0
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
